// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite channel bundle between the load/store bridge (master) and the
// downstream RAM/peripheral fabric (slave).
interface axil_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: turns one core load/store request into one AXI4-Lite
// read or write, single outstanding, and returns a one-cycle response pulse.
// Optional feature macro: AXIL_BRIDGE_ALIGN_CHECK_EN -- when defined, a
// request whose address is not aligned to the bus word is answered locally
// with an error pulse and never reaches the bus.
module axil_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    axil_master_bridge_if.master  m_axil
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_req_ready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_arvalid;
    logic                  r_bready;
    logic                  r_rready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;

    logic                  w_req_ready_nxt;
    logic                  w_awvalid_nxt;
    logic                  w_wvalid_nxt;
    logic                  w_arvalid_nxt;
    logic                  w_bready_nxt;
    logic                  w_rready_nxt;
    logic                  w_resp_valid_nxt;
    logic                  w_resp_err_nxt;
    logic [DATA_WIDTH-1:0] w_resp_rdata_nxt;
    logic                  w_load_req;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_b_hs;
    logic                  w_r_hs;

    // req_ready is only ever high in IDLE, so this is the sole acceptance point
    assign w_accept = req_valid & r_req_ready;
    assign w_aw_hs  = r_awvalid & m_axil.awready;
    assign w_w_hs   = r_wvalid  & m_axil.wready;
    assign w_ar_hs  = r_arvalid & m_axil.arready;
    assign w_b_hs   = r_bready  & m_axil.bvalid;
    assign w_r_hs   = r_rready  & m_axil.rvalid;

`ifdef AXIL_BRIDGE_ALIGN_CHECK_EN
    localparam int LSB_W = $clog2(STRB_WIDTH);
    assign w_misaligned = (req_addr[LSB_W-1:0] != {LSB_W{1'b0}});
`else
    // Low address bits are forwarded untouched; the slave decides alignment
    assign w_misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: leave IDLE on an issued request, return on B/R handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misaligned) begin
                    w_state_nxt = req_we ? S_WRITE : S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (w_b_hs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_READ: begin
                if (w_r_hs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: next value of every registered output plus the capture strobe
    always_comb begin
        w_awvalid_nxt    = 1'b0;
        w_wvalid_nxt     = 1'b0;
        w_arvalid_nxt    = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = r_resp_err;
        w_resp_rdata_nxt = r_resp_rdata;
        w_load_req       = 1'b0;
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_bready_nxt     = (w_state_nxt == S_WRITE);
        w_rready_nxt     = (w_state_nxt == S_READ);
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_misaligned) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                end else if (w_accept) begin
                    w_load_req    = 1'b1;
                    w_awvalid_nxt = req_we;
                    w_wvalid_nxt  = req_we;
                    w_arvalid_nxt = ~req_we;
                end else begin
                    w_load_req = 1'b0;
                end
            end
            S_WRITE: begin
                // AW and W retire independently; a B response closes both regardless
                w_awvalid_nxt = r_awvalid & ~w_aw_hs & ~w_b_hs;
                w_wvalid_nxt  = r_wvalid  & ~w_w_hs  & ~w_b_hs;
                if (w_b_hs) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = (m_axil.bresp != 2'b00);
                end else begin
                    w_resp_valid_nxt = 1'b0;
                end
            end
            S_READ: begin
                w_arvalid_nxt = r_arvalid & ~w_ar_hs & ~w_r_hs;
                if (w_r_hs) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = (m_axil.rresp != 2'b00);
                    w_resp_rdata_nxt = m_axil.rdata;
                end else begin
                    w_resp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_resp_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and request-capture registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req_ready  <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= {DATA_WIDTH{1'b0}};
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_wdata      <= {DATA_WIDTH{1'b0}};
            r_wstrb      <= {STRB_WIDTH{1'b0}};
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_rready     <= w_rready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            if (w_load_req) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign resp_rdata     = r_resp_rdata;

    assign m_axil.awaddr  = r_addr;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_addr;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Testbench for axil_master_bridge: table-driven directed vectors, hand-written
// corner sequences (reset, back-to-back, mid-transaction reset, misaligned
// address) and randomized traffic against a word-array reference model.
module tb_axil_master_bridge;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    axil_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) axil ();

    axil_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axil(axil)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave environment ----------------
    logic [31:0] mem [0:63];
    int          cfg_aw_d, cfg_w_d, cfg_ar_d, cfg_b_d, cfg_r_d;
    logic [1:0]  cfg_bresp, cfg_rresp;
    int          n_aw, n_w, n_ar, n_b, n_r, viol;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    initial begin : slave_model
        bit got_aw, got_w, got_ar, b_pend, r_pend;
        int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
        bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
        logic [31:0] p_awaddr, p_wdata, p_araddr, wd;
        logic [3:0]  p_wstrb;
        got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; viol = 0;
        cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_araddr = 32'h0; cap_wstrb = 4'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
        axil.bvalid = 1'b0; axil.bresp = 2'b00;
        axil.rvalid = 1'b0; axil.rresp = 2'b00; axil.rdata = 32'h0;
        forever begin
            @(posedge clk);
            p_awv = axil.awvalid; p_awr = axil.awready; p_wv = axil.wvalid; p_wr = axil.wready;
            p_arv = axil.arvalid; p_arr = axil.arready; p_bv = axil.bvalid; p_br = axil.bready;
            p_rv = axil.rvalid; p_rr = axil.rready;
            p_awaddr = axil.awaddr; p_wdata = axil.wdata; p_wstrb = axil.wstrb; p_araddr = axil.araddr;
            #1;
            if (!rstn) begin
                got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
                axil.bvalid = 1'b0; axil.rvalid = 1'b0;
            end else begin
                // a valid must hold until its handshake and drop right after it
                if (p_awv && !p_awr && !axil.awvalid) viol++;
                if (p_awv &&  p_awr &&  axil.awvalid) viol++;
                if (p_wv  && !p_wr  && !axil.wvalid)  viol++;
                if (p_wv  &&  p_wr  &&  axil.wvalid)  viol++;
                if (p_arv && !p_arr && !axil.arvalid) viol++;
                if (p_arv &&  p_arr &&  axil.arvalid) viol++;
                if (p_bv && p_br) begin
                    axil.bvalid = 1'b0; got_aw = 0; got_w = 0; b_pend = 0; n_b++;
                end
                if (p_rv && p_rr) begin
                    axil.rvalid = 1'b0; got_ar = 0; r_pend = 0; n_r++;
                end
                if (p_awv && p_awr) begin got_aw = 1; cap_awaddr = p_awaddr; n_aw++; end
                if (p_wv && p_wr) begin got_w = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; n_w++; end
                if (p_arv && p_arr) begin got_ar = 1; cap_araddr = p_araddr; n_ar++; end
                aw_wait = (p_awv && !p_awr) ? aw_wait + 1 : 0;
                w_wait  = (p_wv  && !p_wr)  ? w_wait + 1  : 0;
                ar_wait = (p_arv && !p_arr) ? ar_wait + 1 : 0;
                if (got_aw && got_w && !b_pend) begin
                    wd = mem[cap_awaddr[7:2]];
                    for (int b = 0; b < 4; b++)
                        if (cap_wstrb[b]) wd[b*8 +: 8] = cap_wdata[b*8 +: 8];
                    mem[cap_awaddr[7:2]] = wd;
                    b_pend = 1; b_cnt = 0;
                end
                if (got_ar && !r_pend) begin
                    axil.rdata = mem[cap_araddr[7:2]];
                    r_pend = 1; r_cnt = 0;
                end
                if (b_pend && !axil.bvalid) begin
                    if (b_cnt >= cfg_b_d) begin axil.bvalid = 1'b1; axil.bresp = cfg_bresp; end
                    else b_cnt++;
                end
                if (r_pend && !axil.rvalid) begin
                    if (r_cnt >= cfg_r_d) begin axil.rvalid = 1'b1; axil.rresp = cfg_rresp; end
                    else r_cnt++;
                end
                axil.awready = !got_aw && (aw_wait >= cfg_aw_d);
                axil.wready  = !got_w  && (w_wait  >= cfg_w_d);
                axil.arready = !got_ar && (ar_wait >= cfg_ar_d);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic set_cfg(input int aw, input int w, input int ar, input int b, input int r,
                           input logic [1:0] br, input logic [1:0] rr);
        cfg_aw_d = aw; cfg_w_d = w; cfg_ar_d = ar; cfg_b_d = b; cfg_r_d = r;
        cfg_bresp = br; cfg_rresp = rr;
    endtask

    // One request from drive to response, with every observable checked
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata, input bit exp_err,
                          input int exp_lat, input bit exp_issue, input string name);
        int s_aw, s_w, s_ar, lat;
        bit got;
        s_aw = n_aw; s_w = n_w; s_ar = n_ar;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1;
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s/accept: req_ready never seen within 60 cycles", name);
            return;
        end
        @(negedge clk);
        check({name, "/awvalid_n1"}, {31'h0, axil.awvalid}, {31'h0, we & exp_issue});
        check({name, "/wvalid_n1"},  {31'h0, axil.wvalid},  {31'h0, we & exp_issue});
        check({name, "/arvalid_n1"}, {31'h0, axil.arvalid}, {31'h0, ~we & exp_issue});
        if (!we && exp_issue) check({name, "/araddr_n1"}, axil.araddr, addr);
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, lat, exp_lat);
        check({name, "/resp_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        if (!we || !exp_issue) check({name, "/resp_rdata"}, resp_rdata, exp_rdata);
        @(negedge clk);
        check({name, "/resp_pulse"}, {31'h0, resp_valid}, 32'h0);
        check({name, "/n_aw"}, n_aw - s_aw, (we && exp_issue) ? 1 : 0);
        check({name, "/n_w"},  n_w - s_w,   (we && exp_issue) ? 1 : 0);
        check({name, "/n_ar"}, n_ar - s_ar, (!we && exp_issue) ? 1 : 0);
        if (we && exp_issue) begin
            check({name, "/awaddr"}, cap_awaddr, addr);
            check({name, "/wdata"},  cap_wdata,  wdata);
            check({name, "/wstrb"},  {28'h0, cap_wstrb}, {28'h0, wstrb});
        end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, ar_d, b_d, r_d;
        logic [1:0]  bresp, rresp;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        string       name;
    } vec_t;

    function automatic vec_t mkv(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                                 int aw_d, int w_d, int ar_d, int b_d, int r_d,
                                 logic [1:0] bresp, logic [1:0] rresp,
                                 logic [31:0] exp_rdata, bit exp_err, int exp_lat, string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_d = aw_d; v.w_d = w_d; v.ar_d = ar_d; v.b_d = b_d; v.r_d = r_d;
        v.bresp = bresp; v.rresp = rresp;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.name = name;
        return v;
    endfunction

    vec_t vecs [13];

    initial begin : main
        bit          we, mis;
        int          idx, lo, aw, w, ar, b, r, lat;
        logic [31:0] addr, wdata, exp_rd;
        logic [3:0]  strb;
        logic [1:0]  br, rr;
        bit          align_en;
`ifdef AXIL_BRIDGE_ALIGN_CHECK_EN
        align_en = 1'b1;
`else
        align_en = 1'b0;
`endif
        vecs[0]  = mkv(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        1'b0, 3, "wr_deadbeef");
        vecs[1]  = mkv(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF, 1'b0, 3, "rd_deadbeef");
        vecs[2]  = mkv(1'b1, 32'h10, 32'h0000CAFE, 4'h3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        1'b0, 3, "wr_cafe_lo");
        vecs[3]  = mkv(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADCAFE, 1'b0, 3, "rd_deadcafe");
        vecs[4]  = mkv(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 4, 0, 0, 0, 2'b00, 2'b00, 32'h0,        1'b0, 7, "wr_aw1_w4");
        vecs[5]  = mkv(1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 2, 0, 1, 2'b00, 2'b00, 32'h11223344, 1'b0, 6, "rd_ar2_r1");
        vecs[6]  = mkv(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        1'b0, 3, "wr_strb0");
        vecs[7]  = mkv(1'b0, 32'h24, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        1'b0, 3, "rd_strb0");
        vecs[8]  = mkv(1'b1, 32'h30, 32'h5555AAAA, 4'hF, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0,        1'b1, 3, "wr_slverr");
        vecs[9]  = mkv(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'hDEADCAFE, 1'b1, 3, "rd_decerr");
        vecs[10] = mkv(1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h5555AAAA, 1'b0, 3, "rd_after_err");
        vecs[11] = mkv(1'b1, 32'h14, 32'h01020304, 4'hC, 3, 0, 0, 2, 0, 2'b00, 2'b00, 32'h0,        1'b0, 8, "wr_aw3_b2");
        vecs[12] = mkv(1'b0, 32'h14, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h01020000, 1'b0, 3, "rd_hi_half");

        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        last_rdata = 32'h0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;

        // reset values and req_ready rising one clock after release
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/req_ready",  {31'h0, req_ready},    32'h0);
        check("rst/resp_valid", {31'h0, resp_valid},   32'h0);
        check("rst/resp_err",   {31'h0, resp_err},     32'h0);
        check("rst/resp_rdata", resp_rdata,            32'h0);
        check("rst/valids",     {29'h0, axil.awvalid, axil.wvalid, axil.arvalid}, 32'h0);
        check("rst/readies",    {30'h0, axil.bready, axil.rready}, 32'h0);
        rstn = 1'b1;
        #1;
        check("rst/req_ready_release", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("rst/req_ready_first_clk", {31'h0, req_ready}, 32'h1);

        // table-driven directed vectors
        for (int i = 0; i < 13; i++) begin
            set_cfg(vecs[i].aw_d, vecs[i].w_d, vecs[i].ar_d, vecs[i].b_d, vecs[i].r_d,
                    vecs[i].bresp, vecs[i].rresp);
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata,
                   vecs[i].exp_err, vecs[i].exp_lat, 1'b1, vecs[i].name);
            if (vecs[i].we) ref_mem[vecs[i].addr[7:2]] = merge(ref_mem[vecs[i].addr[7:2]], vecs[i].wdata, vecs[i].wstrb);
            else last_rdata = vecs[i].exp_rdata;
        end

        // back-to-back: a read presented in the write's response cycle is taken there
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hA5A55A5A; req_wstrb = 4'hF;
        @(negedge clk);
        check("b2b/req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_mem[16] = merge(ref_mem[16], 32'hA5A55A5A, 4'hF);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 60);
        check("b2b/wr_latency", lat, 3);
        check("b2b/ready_in_resp", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b/arvalid", {31'h0, axil.arvalid}, 32'h1);
        lat = 1;
        while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
        check("b2b/rd_latency", lat, 3);
        check("b2b/rdata", resp_rdata, ref_mem[16]);
        last_rdata = ref_mem[16];

        // reset in the middle of a stalled write drops every valid/ready at once
        set_cfg(5, 5, 0, 0, 0, 2'b00, 2'b00);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mrst/awvalid_before", {31'h0, axil.awvalid}, 32'h1);
        rstn = 1'b0;
        #1;
        check("mrst/valids", {29'h0, axil.awvalid, axil.wvalid, axil.arvalid}, 32'h0);
        check("mrst/bready_req_ready", {30'h0, axil.bready, req_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mrst/req_ready_back", {31'h0, req_ready}, 32'h1);
        last_rdata = 32'h0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        do_txn(1'b0, 32'h44, 32'h0, 4'h0, ref_mem[17], 1'b0, 3, 1'b1, "mrst_read");
        last_rdata = ref_mem[17];

        // misaligned read of 0x13
        if (align_en) begin
            do_txn(1'b0, 32'h13, 32'h0, 4'h0, last_rdata, 1'b1, 1, 1'b0, "misaligned_rd");
        end else begin
            do_txn(1'b0, 32'h13, 32'h0, 4'h0, ref_mem[4], 1'b0, 3, 1'b1, "misaligned_rd");
            last_rdata = ref_mem[4];
        end

        // randomized traffic against the word-array model
        for (int t = 0; t < 40; t++) begin
            we    = 1'($urandom_range(0, 1));
            idx   = int'($urandom_range(0, 63));
            lo    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            addr  = 32'(idx * 4 + lo);
            wdata = $urandom;
            strb  = 4'($urandom_range(0, 15));
            aw = int'($urandom_range(0, 3)); w = int'($urandom_range(0, 3));
            ar = int'($urandom_range(0, 3)); b = int'($urandom_range(0, 2)); r = int'($urandom_range(0, 2));
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            set_cfg(aw, w, ar, b, r, br, rr);
            mis = align_en && (lo != 0);
            if (mis) begin
                do_txn(we, addr, wdata, strb, last_rdata, 1'b1, 1, 1'b0, "rnd_mis");
            end else if (we) begin
                do_txn(we, addr, wdata, strb, 32'h0, br != 2'b00, 3 + ((aw > w) ? aw : w) + b, 1'b1, "rnd_wr");
                ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
            end else begin
                exp_rd = ref_mem[idx];
                do_txn(we, addr, wdata, strb, exp_rd, rr != 2'b00, 3 + ar + r, 1'b1, "rnd_rd");
                last_rdata = exp_rd;
            end
        end

        check("protocol/valid_hold_drop_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
